// File: rtl/mlp_axis_pkg.sv
// Types and constants shared by the MLP input stream slave and output stream master.
package mlp_axis_pkg;

    localparam int BEAT_CNT_W     = 10;
    localparam int DEFAULT_DATA_W = 32;

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } frame_state_e;

endpackage

// File: rtl/sync_fifo_fwft.sv
// Single-clock first-word-fall-through FIFO; occupancy is tracked in its own
// counter so full and empty never depend on pointer comparison.
module sync_fifo_fwft #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 16,
    localparam int PTR_W  = $clog2(DEPTH),
    localparam int CNT_W  = PTR_W + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic              full,
    output logic              empty,
    output logic [CNT_W-1:0]  count
);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              push;
    logic              pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign push  = wr_en && !full;
    assign pop   = rd_en && !empty;

    // Head word is gated so the data output reads zero whenever nothing is buffered.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/axis_slave.sv
// AXI4-Stream receiver feeding the MLP core: FWFT buffering plus a per-layer
// frame-length check against TLAST.
module axis_slave
    import mlp_axis_pkg::*;
#(
    parameter int C_S_AXIS_TDATA_WIDTH = DEFAULT_DATA_W,
    parameter int FIFO_DEPTH           = 16
) (
    input  logic                              S_AXIS_ACLK,
    input  logic                              S_AXIS_ARESET,
    input  logic                              S_AXIS_TVALID,
    output logic                              S_AXIS_TREADY,
    input  logic [C_S_AXIS_TDATA_WIDTH-1:0]   S_AXIS_TDATA,
    input  logic [C_S_AXIS_TDATA_WIDTH/8-1:0] S_AXIS_TSTRB,
    input  logic                              S_AXIS_TLAST,
    input  logic [BEAT_CNT_W-1:0]             pi_expected_beats,
    input  logic                              pi_read_from_fifo,
    input  logic                              pi_clear_error,
    output logic [C_S_AXIS_TDATA_WIDTH-1:0]   po_mlp_data,
    output logic                              po_data_valid,
    output logic                              po_frame_done,
    output logic                              po_tlast_error,
    output logic [$clog2(FIFO_DEPTH):0]       po_fifo_count,
    output frame_state_e                      dbg_state
);

    // Handshakes: a stream beat transfers on any rising edge with TVALID && TREADY;
    // a word is consumed on any rising edge with pi_read_from_fifo && po_data_valid.
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  beat_acc;
    logic                  unused_tstrb;

    frame_state_e          state, state_nxt;
    logic [BEAT_CNT_W-1:0] beat_cnt, beat_nxt;
    logic [BEAT_CNT_W-1:0] exp_reg, exp_nxt;
    logic [BEAT_CNT_W-1:0] beat_num;
    logic [BEAT_CNT_W-1:0] exp_cur;
    logic                  len_hit;
    logic                  frame_ok;
    logic                  frame_bad;

    assign unused_tstrb  = ^S_AXIS_TSTRB;
    assign S_AXIS_TREADY = !fifo_full && !S_AXIS_ARESET;
    assign beat_acc      = S_AXIS_TVALID && S_AXIS_TREADY;
    assign po_data_valid = !fifo_empty;
    assign dbg_state     = state;

    sync_fifo_fwft #(
        .DATA_W (C_S_AXIS_TDATA_WIDTH),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk     (S_AXIS_ACLK),
        .rst     (S_AXIS_ARESET),
        .wr_en   (beat_acc),
        .wr_data (S_AXIS_TDATA),
        .rd_en   (pi_read_from_fifo),
        .rd_data (po_mlp_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (po_fifo_count)
    );

    // The first beat of a frame uses the live length input; later beats use the latched copy.
    assign beat_num = (state == IDLE) ? BEAT_CNT_W'(1) : beat_cnt + BEAT_CNT_W'(1);
    assign exp_cur  = (state == IDLE) ? pi_expected_beats : exp_reg;
    assign len_hit  = (exp_cur != '0) && (beat_num == exp_cur);

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat_cnt;
        exp_nxt   = exp_reg;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        if (beat_acc) begin
            exp_nxt = exp_cur;
            if (exp_cur == '0) begin
                frame_ok = S_AXIS_TLAST;
            end else begin
                frame_ok  = S_AXIS_TLAST && len_hit;
                frame_bad = S_AXIS_TLAST ^ len_hit;
            end
            if (frame_ok || frame_bad) begin
                state_nxt = IDLE;
                beat_nxt  = '0;
            end else begin
                state_nxt = RECV;
                beat_nxt  = beat_num;
            end
        end
    end

    always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
        if (S_AXIS_ARESET) begin
            state          <= IDLE;
            beat_cnt       <= '0;
            exp_reg        <= '0;
            po_frame_done  <= 1'b0;
            po_tlast_error <= 1'b0;
        end else begin
            state         <= state_nxt;
            beat_cnt      <= beat_nxt;
            exp_reg       <= exp_nxt;
            po_frame_done <= frame_ok;
            // A fresh mismatch outranks a clear arriving in the same cycle.
            if (frame_bad) begin
                po_tlast_error <= 1'b1;
            end else if (pi_clear_error) begin
                po_tlast_error <= 1'b0;
            end
        end
    end

endmodule
